// File: rtl/ram_access_arbiter.sv
// Weighted arbiter sharing one single-port RAM between the decoder core and the
// input loader, with read-data steering and a contiguous "loaded" watermark.
module ram_access_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 64,
  parameter int CORE_WEIGHT = 3
) (
  input  logic              clk,
  input  logic              resetB,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_clear,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_pause,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              ram_ceb,
  output logic              ram_web,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W:0]   good_addr,
  output logic              load_done
);

  localparam logic [2:0]      WEIGHT     = 3'(CORE_WEIGHT);
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_COUNT  = {{ADDR_W{1'b0}}, 1'b1};

  logic              core_elig_s;
  logic              ld_elig_s;
  logic              ld_gnt_s;
  logic              core_gnt_s;
  logic              any_gnt_s;
  logic              cmd_we_s;
  logic [ADDR_W-1:0] cmd_addr_s;
  logic [DATA_W-1:0] cmd_wdata_s;
  logic              wm_advance_s;
  logic [ADDR_W:0]   good_next_s;

  logic [2:0]        wcnt_r;
  logic [1:0]        tag_v_r;
  logic [1:0]        tag_core_r;

  // Eligibility and single-winner grant; core reads above the watermark are held off.
  always_comb begin
    core_elig_s = core_req & (core_we | ({1'b0, core_addr} < good_addr));
    ld_elig_s   = ld_req;
    ld_gnt_s    = 1'b0;
    core_gnt_s  = 1'b0;
    if (!resetB) begin
      ld_gnt_s   = 1'b0;
      core_gnt_s = 1'b0;
    end else if (core_elig_s && ld_elig_s) begin
      if (wcnt_r < WEIGHT) begin
        core_gnt_s = 1'b1;
      end else begin
        ld_gnt_s = 1'b1;
      end
    end else if (core_elig_s) begin
      core_gnt_s = 1'b1;
    end else if (ld_elig_s) begin
      ld_gnt_s = 1'b1;
    end else begin
      ld_gnt_s   = 1'b0;
      core_gnt_s = 1'b0;
    end
    any_gnt_s = ld_gnt_s | core_gnt_s;
  end

  assign ld_gnt     = ld_gnt_s;
  assign core_gnt   = core_gnt_s;
  assign core_pause = resetB & core_req & ~core_gnt_s;

  // Command source select for the winning requester.
  always_comb begin
    cmd_we_s    = 1'b0;
    cmd_addr_s  = {ADDR_W{1'b0}};
    cmd_wdata_s = {DATA_W{1'b0}};
    if (core_gnt_s) begin
      cmd_we_s    = core_we;
      cmd_addr_s  = core_addr;
      cmd_wdata_s = core_we ? core_wdata : {DATA_W{1'b0}};
    end else if (ld_gnt_s) begin
      cmd_we_s    = ld_we;
      cmd_addr_s  = ld_addr;
      cmd_wdata_s = ld_we ? ld_wdata : {DATA_W{1'b0}};
    end else begin
      cmd_we_s    = 1'b0;
      cmd_addr_s  = ram_addr;
      cmd_wdata_s = ram_wdata;
    end
  end

  // Watermark advances only on an in-order loader write while not yet full.
  always_comb begin
    wm_advance_s = ld_gnt_s & ld_we & ~load_done & (ld_addr == good_addr[ADDR_W-1:0]);
    good_next_s  = good_addr + ONE_COUNT;
  end

  // Registered RAM command; addr/wdata hold while idle.
  always_ff @(posedge clk) begin
    if (!resetB) begin
      ram_ceb   <= 1'b1;
      ram_web   <= 1'b1;
      ram_addr  <= {ADDR_W{1'b0}};
      ram_wdata <= {DATA_W{1'b0}};
    end else if (any_gnt_s) begin
      ram_ceb   <= 1'b0;
      ram_web   <= ~cmd_we_s;
      ram_addr  <= cmd_addr_s;
      ram_wdata <= cmd_wdata_s;
    end else begin
      ram_ceb   <= 1'b1;
      ram_web   <= 1'b1;
      ram_addr  <= cmd_addr_s;
      ram_wdata <= cmd_wdata_s;
    end
  end

  // Weight counter: saturating on core grants, cleared when the loader gets its slot.
  always_ff @(posedge clk) begin
    if (!resetB) begin
      wcnt_r <= 3'd0;
    end else if (core_gnt_s) begin
      if (wcnt_r < WEIGHT) begin
        wcnt_r <= wcnt_r + 3'd1;
      end else begin
        wcnt_r <= wcnt_r;
      end
    end else if (ld_gnt_s) begin
      wcnt_r <= 3'd0;
    end else begin
      wcnt_r <= wcnt_r;
    end
  end

  // Read tag pipe {valid, owner}; the output registers form its last stage.
  always_ff @(posedge clk) begin
    if (!resetB) begin
      tag_v_r     <= 2'b00;
      tag_core_r  <= 2'b00;
      ld_rvalid   <= 1'b0;
      core_rvalid <= 1'b0;
      ld_rdata    <= {DATA_W{1'b0}};
      core_rdata  <= {DATA_W{1'b0}};
    end else begin
      tag_v_r[0]    <= any_gnt_s & ~cmd_we_s;
      tag_core_r[0] <= core_gnt_s;
      tag_v_r[1]    <= tag_v_r[0];
      tag_core_r[1] <= tag_core_r[0];
      ld_rvalid     <= tag_v_r[1] & ~tag_core_r[1];
      core_rvalid   <= tag_v_r[1] & tag_core_r[1];
      if (tag_v_r[1] && !tag_core_r[1]) begin
        ld_rdata <= ram_rdata;
      end else begin
        ld_rdata <= ld_rdata;
      end
      if (tag_v_r[1] && tag_core_r[1]) begin
        core_rdata <= ram_rdata;
      end else begin
        core_rdata <= core_rdata;
      end
    end
  end

  // Contiguous-load watermark; a clear overrides a same-cycle advance.
  always_ff @(posedge clk) begin
    if (!resetB) begin
      good_addr <= {(ADDR_W+1){1'b0}};
      load_done <= 1'b0;
    end else if (ld_clear) begin
      good_addr <= {(ADDR_W+1){1'b0}};
      load_done <= 1'b0;
    end else if (wm_advance_s) begin
      good_addr <= good_next_s;
      load_done <= (good_next_s == FULL_COUNT);
    end else begin
      good_addr <= good_addr;
      load_done <= load_done;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: grant/watermark checks inline, read data
// and latency checked by a scoreboard monitor against a behavioural RAM.
module tb_ram_access_arbiter;

  logic        clk;
  logic        resetB;
  logic        ld_req, ld_we, ld_clear;
  logic [9:0]  ld_addr;
  logic [63:0] ld_wdata;
  logic        ld_gnt, ld_rvalid;
  logic [63:0] ld_rdata;
  logic        core_req, core_we;
  logic [9:0]  core_addr;
  logic [63:0] core_wdata;
  logic        core_gnt, core_pause, core_rvalid;
  logic [63:0] core_rdata;
  logic        ram_ceb, ram_web;
  logic [9:0]  ram_addr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_rdata;
  logic [10:0] good_addr;
  logic        load_done;

  ram_access_arbiter dut (
    .clk(clk), .resetB(resetB),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_clear(ld_clear), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_pause(core_pause), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .ram_ceb(ram_ceb), .ram_web(ram_web), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .good_addr(good_addr), .load_done(load_done)
  );

  typedef struct {
    logic [63:0] d;
    int          c;
  } exp_t;

  exp_t        ld_q[$];
  exp_t        core_q[$];
  logic [63:0] ram_mem [0:1023];
  logic [63:0] model [0:1023];
  int          exp_good;
  int          cyc;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM: read data appears the cycle after the command.
  always @(posedge clk) begin
    if (!ram_ceb) begin
      if (!ram_web) ram_mem[ram_addr] <= ram_wdata;
      else          ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    exp_t e;
    if (resetB === 1'b1) begin
      if (ld_rvalid) begin
        if (ld_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ld_rvalid_unexpected actual=1 expected=0 (t=%0t)", $time);
        end else begin
          e = ld_q.pop_front();
          chk("ld_rdata", ld_rdata, e.d);
          chk("ld_latency", 64'(cyc), 64'(e.c));
        end
      end
      if (core_rvalid) begin
        if (core_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL core_rvalid_unexpected actual=1 expected=0 (t=%0t)", $time);
        end else begin
          e = core_q.pop_front();
          chk("core_rdata", core_rdata, e.d);
          chk("core_latency", 64'(cyc), 64'(e.c));
        end
      end
    end
  end

  task automatic apply_ld_write(input logic [9:0] a, input logic [63:0] d, input logic clr);
    model[a] = d;
    if (clr) exp_good = 0;
    else if (exp_good < 1024 && int'(a) == exp_good) exp_good++;
  endtask

  // Loader access on its own; starts and ends just after a rising edge.
  task automatic ld_access(input logic we, input logic [9:0] a, input logic [63:0] d,
                           input logic expect_first);
    int w;
    w = 0;
    ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
    @(negedge clk);
    while (!ld_gnt && w < 50) begin
      @(posedge clk); #1; @(negedge clk); w++;
    end
    if (!ld_gnt) begin
      checks++; errors++;
      $display("FAIL ld_gnt_timeout actual=0 expected=1 addr=%0d", a);
      @(posedge clk); #1; ld_req = 1'b0;
      return;
    end
    if (expect_first) chk("ld_gnt_wait", 64'(w), 64'd0);
    if (we) apply_ld_write(a, d, 1'b0);
    else    ld_q.push_back('{model[a], cyc + 3});
    @(posedge clk); #1;
    ld_req = 1'b0;
    chk("ram_ceb_cmd", {63'd0, ram_ceb}, 64'd0);
    chk("ram_web_cmd", {63'd0, ram_web}, {63'd0, ~we});
    chk("ram_addr_cmd", {54'd0, ram_addr}, {54'd0, a});
  endtask

  initial begin
    logic exp_l;
    checks = 0; errors = 0; cyc = 0; exp_good = 0;
    for (int i = 0; i < 1024; i++) begin
      model[i] = 64'd0;
      ram_mem[i] = 64'd0;
    end
    ram_rdata = 64'd0;
    resetB = 1'b0; ld_clear = 1'b0;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'd0; ld_wdata = 64'd1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 10'd0; core_wdata = 64'd2;

    // Reset with both requests held
    repeat (2) @(posedge clk);
    #1; @(negedge clk);
    chk("rst_ld_gnt", {63'd0, ld_gnt}, 64'd0);
    chk("rst_core_gnt", {63'd0, core_gnt}, 64'd0);
    chk("rst_core_pause", {63'd0, core_pause}, 64'd0);
    ld_req = 1'b0; core_req = 1'b0; resetB = 1'b1;
    @(posedge clk); #1;
    chk("rst_ram_ceb", {63'd0, ram_ceb}, 64'd1);
    chk("rst_ram_web", {63'd0, ram_web}, 64'd1);
    chk("rst_good_addr", {53'd0, good_addr}, 64'd0);
    chk("rst_load_done", {63'd0, load_done}, 64'd0);

    // Sequential loader writes 0..9
    for (int a = 0; a < 10; a++)
      ld_access(1'b1, 10'(a), 64'h1000_0000_0000_0000 + 64'(a * 7), 1'b1);
    chk("wm_after_10", {53'd0, good_addr}, 64'(exp_good));
    chk("wm_is_10", 64'(exp_good), 64'd10);

    // Both requesting: C,C,C,L; loader repeats addr 5 so the watermark stays
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'd5; ld_wdata = 64'h5555_0000_0000_0000;
    core_req = 1'b1; core_we = 1'b1; core_addr = 10'd100; core_wdata = 64'hC0DE_0000_0000_0064;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_l = ((i % 4) == 3);
      chk("wt_core_gnt", {63'd0, core_gnt}, {63'd0, ~exp_l});
      chk("wt_ld_gnt", {63'd0, ld_gnt}, {63'd0, exp_l});
      chk("wt_core_pause", {63'd0, core_pause}, {63'd0, exp_l});
      if (exp_l) apply_ld_write(ld_addr, ld_wdata, 1'b0);
      else       model[core_addr] = core_wdata;
      @(posedge clk); #1;
      core_addr = 10'(101 + i);
      core_wdata = 64'hC0DE_0000_0000_0000 + 64'(101 + i);
      ld_wdata = 64'h5555_0000_0000_0000 + 64'(i + 1);
    end
    ld_req = 1'b0; core_req = 1'b0;
    chk("wm_after_repeat", {53'd0, good_addr}, 64'd10);

    // Core read above watermark stalls until loader fills 10,11,12
    core_req = 1'b1; core_we = 1'b0; core_addr = 10'd12;
    @(negedge clk);
    chk("stall_core_gnt", {63'd0, core_gnt}, 64'd0);
    chk("stall_core_pause", {63'd0, core_pause}, 64'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'(10 + k);
      ld_wdata = 64'hFEED_0000_0000_0000 + 64'(10 + k);
      @(negedge clk);
      chk("fill_ld_gnt", {63'd0, ld_gnt}, 64'd1);
      chk("fill_core_gnt", {63'd0, core_gnt}, 64'd0);
      chk("fill_core_pause", {63'd0, core_pause}, 64'd1);
      apply_ld_write(ld_addr, ld_wdata, 1'b0);
      @(posedge clk); #1;
    end
    ld_req = 1'b0;
    @(negedge clk);
    chk("fill_good_addr", {53'd0, good_addr}, 64'd13);
    chk("unstall_core_gnt", {63'd0, core_gnt}, 64'd1);
    core_q.push_back('{model[12], cyc + 3});
    @(posedge clk); #1;
    core_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Loader read @3 then core read @5 on the next cycle
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'd3;
    @(negedge clk);
    chk("rd_ld_gnt", {63'd0, ld_gnt}, 64'd1);
    ld_q.push_back('{model[3], cyc + 3});
    @(posedge clk); #1;
    ld_req = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = 10'd5;
    @(negedge clk);
    chk("rd_core_gnt", {63'd0, core_gnt}, 64'd1);
    core_q.push_back('{model[5], cyc + 3});
    @(posedge clk); #1;
    core_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Fill the rest so the watermark saturates
    for (int a = 13; a < 1024; a++)
      ld_access(1'b1, 10'(a), 64'hA5A5_0000_0000_0000 + 64'(a), 1'b0);
    chk("full_good_addr", {53'd0, good_addr}, 64'd1024);
    chk("full_load_done", {63'd0, load_done}, 64'd1);
    ld_access(1'b1, 10'd0, 64'h0BAD_0000_0000_0000, 1'b1);
    chk("sat_good_addr", {53'd0, good_addr}, 64'd1024);

    // Clear, then clear racing a qualifying write at addr 0
    ld_clear = 1'b1;
    @(posedge clk); #1;
    ld_clear = 1'b0; exp_good = 0;
    chk("clr_good_addr", {53'd0, good_addr}, 64'd0);
    chk("clr_load_done", {63'd0, load_done}, 64'd0);
    ld_clear = 1'b1; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'd0;
    ld_wdata = 64'h0000_1111_2222_3333;
    @(negedge clk);
    chk("clrw_ld_gnt", {63'd0, ld_gnt}, 64'd1);
    apply_ld_write(10'd0, ld_wdata, 1'b1);
    @(posedge clk); #1;
    ld_clear = 1'b0; ld_req = 1'b0;
    chk("clrw_good_addr", {53'd0, good_addr}, 64'(exp_good));

    // Core read of 0 stalls until the loader rewrites address 0
    core_req = 1'b1; core_we = 1'b0; core_addr = 10'd0;
    repeat (2) begin
      @(negedge clk);
      chk("clr_stall_gnt", {63'd0, core_gnt}, 64'd0);
      chk("clr_stall_pause", {63'd0, core_pause}, 64'd1);
      @(posedge clk); #1;
    end
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'd0; ld_wdata = 64'h7777_8888_9999_AAAA;
    @(negedge clk);
    chk("rewrite_ld_gnt", {63'd0, ld_gnt}, 64'd1);
    apply_ld_write(10'd0, ld_wdata, 1'b0);
    @(posedge clk); #1;
    ld_req = 1'b0;
    @(negedge clk);
    chk("rewrite_good_addr", {53'd0, good_addr}, 64'd1);
    chk("rewrite_core_gnt", {63'd0, core_gnt}, 64'd1);
    core_q.push_back('{model[0], cyc + 3});
    @(posedge clk); #1;
    core_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    chk("ld_q_drained", 64'(ld_q.size()), 64'd0);
    chk("core_q_drained", 64'(core_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single-port 1024x64 data RAM between the core (decoder engine) and the ramloader (input-file loader).
- Weighted priority: the core gets up to CORE_WEIGHT back-to-back grants, then one ramloader slot.
- Registers the RAM command, steers read data back to the owner with a valid pulse, and tracks a contiguous "loaded" watermark.
- Core reads above the watermark stall until the loader has written that address.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 64, RAM data width.
- CORE_WEIGHT, 3, max consecutive core grants while the loader waits; legal range 1..7.

Ports:
- clk  in  1  clock
- resetB  in  1  synchronous active-low reset
- ld_req  in  1  loader access request; held with its fields until ld_gnt
- ld_we  in  1  loader write (1) / read (0)
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_clear  in  1  pulse: restart the load, watermark goes to 0
- ld_gnt  out  1  loader access accepted this cycle
- ld_rvalid  out  1  ld_rdata valid pulse
- ld_rdata  out  DATA_W  loader read data
- core_req  in  1  core access request; held until core_gnt
- core_we  in  1  core write/read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core access accepted this cycle
- core_pause  out  1  core is requesting but not granted
- core_rvalid  out  1  core_rdata valid pulse
- core_rdata  out  DATA_W  core read data
- ram_ceb  out  1  RAM chip enable, active low
- ram_web  out  1  RAM write enable, active low
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read command
- good_addr  out  ADDR_W+1  watermark: count of contiguously loaded words from address 0
- load_done  out  1  good_addr == 2^ADDR_W

Behaviour:
- Reset: clk is the only clock, and resetB is a synchronous active-low reset. While resetB=0, all registers clear on the clk edge.
- Reset values: ram_ceb=1, ram_web=1, ram_addr=0, ram_wdata=0, ld_rvalid=0, core_rvalid=0, ld_rdata=0, core_rdata=0, good_addr=0, load_done=0, wcnt=0, read-tag pipe empty. While resetB=0, ld_gnt, core_gnt and core_pause are forced to 0.
- Eligibility: core_elig = core_req & (core_we | core_addr < good_addr). ld_elig = ld_req.
- Grant is combinational and at most one per cycle:
  - Both eligible: core if wcnt<CORE_WEIGHT, else loader.
  - Only one eligible: that requester.
- wcnt (3 bits) on a core grant: increment, saturating at CORE_WEIGHT.
- wcnt on a loader grant: clear to 0.
- wcnt with no grant: hold.
- A saturated wcnt means the loader wins immediately when it next requests.
- core_pause = core_req & ~core_gnt. This covers loader priority and the watermark interlock. The core holds its request while paused.
- Cycle N (grant): the edge ending N registers ram_ceb=0, ram_web=~we, ram_addr, ram_wdata (wdata is 0 for reads). With no grant: ram_ceb=1, ram_web=1, addr/wdata hold.
- Cycle N+1: the command is on the RAM pins.
- Cycle N+2: ram_rdata is valid.
- Cycle N+3: the owner's rdata is registered and its rvalid=1 for exactly one cycle.
- Read latency from grant to rvalid is 3 cycles.
- A 3-entry tag shift {valid, owner} carries each read. Writes produce no rvalid. rdata holds between pulses.
- Back-to-back reads, including alternating owners, stream at one per cycle.
- Watermark, loader write granted with ld_addr == good_addr[ADDR_W-1:0] and load_done=0: good_addr increments.
- Watermark, out-of-order or repeat loader writes: no change.
- Watermark saturates at 2^ADDR_W and load_done=1.
- ld_clear: good_addr=0, load_done=0. It wins over a same-cycle qualifying write. The write itself is still granted and performed.
- Core writes never move the watermark.
- Reset mid-operation: in-flight reads are discarded and no rvalid follows. RAM is idle (ceb=1) from the first post-reset cycle.

Test Plan:
- Reset with ld_req=core_req=1 held -> ld_gnt=core_gnt=core_pause=0; ram_ceb=1, good_addr=0 after the release edge.
- Loader writes addr 0..9 sequentially, no core -> 10 consecutive ld_gnt; good_addr=10; ram_web=0 one cycle after each grant.
- Both request continuously, core writes -> grant pattern C,C,C,L repeating; core_pause=1 exactly on L cycles.
- Core read addr 12 with good_addr=10 -> core_pause=1 and no grant. Loader writes 10,11,12; core granted the cycle after good_addr=13. core_rvalid 3 cycles later with core_rdata = the value written at 12.
- Interleaved reads loader@3 then core@5, next cycle -> ld_rvalid then core_rvalid on consecutive cycles with the correct data.
- ld_clear with good_addr=1024 (load_done=1) -> good_addr=0, load_done=0; a core read of addr 0 stalls until the loader rewrites addr 0.
